// File: rtl/proc_core.sv
// Single-issue channel processor with local program memory, register file, ALU and a
// free-running qclk. It emits qclk-timed command strobes and blocks on sync/fproc handshakes.
module proc_core #(
  parameter int DATA_WIDTH         = 32,
  parameter int CMD_WIDTH          = 128,
  parameter int CMD_ADDR_WIDTH     = 8,
  parameter int REG_ADDR_WIDTH     = 4,
  parameter int SYNC_BARRIER_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          write_prog_enable,
  input  logic [CMD_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [CMD_WIDTH-1:0]          cmd_data,
  input  logic                          sync_enable,
  input  logic                          fproc_enable,
  input  logic [DATA_WIDTH-1:0]         fproc_data,
  output logic [CMD_WIDTH-1:0]          cmd_out,
  output logic                          cstrobe,
  output logic [SYNC_BARRIER_WIDTH-1:0] sync_barrier,
  output logic                          sync_barrier_en_out,
  output logic [SYNC_BARRIER_WIDTH-1:0] fproc_id,
  output logic                          fproc_en_out,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    state_dbg
);

  localparam int NUM_REGS   = 1 << REG_ADDR_WIDTH;
  localparam int PROG_DEPTH = 1 << CMD_ADDR_WIDTH;

  // Instruction field positions, MSB first.
  localparam int OPC_LSB    = CMD_WIDTH - 8;
  localparam int ALU_LSB    = CMD_WIDTH - 11;
  localparam int IMMSEL_BIT = CMD_WIDTH - 12;
  localparam int RD_LSB     = CMD_WIDTH - 20;
  localparam int RS0_LSB    = CMD_WIDTH - 28;
  localparam int RS1_LSB    = CMD_WIDTH - 36;
  localparam int IMM_LSB    = CMD_WIDTH - 36 - DATA_WIDTH;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ALU       = 8'h01;
  localparam logic [7:0] OP_JUMP      = 8'h02;
  localparam logic [7:0] OP_JUMP_COND = 8'h03;
  localparam logic [7:0] OP_PULSE     = 8'h04;
  localparam logic [7:0] OP_SYNC      = 8'h05;
  localparam logic [7:0] OP_FPROC     = 8'h06;
  localparam logic [7:0] OP_DONE      = 8'h07;
  localparam logic [7:0] OP_QCLK_RST  = 8'h08;

  localparam logic [CMD_ADDR_WIDTH-1:0] PC_ONE   = CMD_ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0]     QCLK_ONE = DATA_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH      = 3'd1,
    S_EXEC       = 3'd2,
    S_WAIT_PULSE = 3'd3,
    S_WAIT_SYNC  = 3'd4,
    S_WAIT_FPROC = 3'd5,
    S_DONE       = 3'd6
  } state_t;

  state_t                    state;
  logic [CMD_ADDR_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0]     qclk;
  logic [CMD_WIDTH-1:0]      instr;
  logic [DATA_WIDTH-1:0]     rf       [NUM_REGS];
  logic [CMD_WIDTH-1:0]      prog_mem [PROG_DEPTH];

  logic [7:0]                opcode;
  logic [2:0]                alu_op;
  logic                      imm_sel;
  logic [REG_ADDR_WIDTH-1:0] rd_idx;
  logic [REG_ADDR_WIDTH-1:0] rs0_idx;
  logic [REG_ADDR_WIDTH-1:0] rs1_idx;
  logic [DATA_WIDTH-1:0]     imm;
  logic [DATA_WIDTH-1:0]     alu_in0;
  logic [DATA_WIDTH-1:0]     alu_in1;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic [CMD_ADDR_WIDTH-1:0] pc_inc;
  logic [CMD_ADDR_WIDTH-1:0] jump_target;
  logic                      pulse_ready;
  logic                      idle_like;

  assign state_dbg = state;
  assign idle_like = (state == S_IDLE) || (state == S_DONE);

  assign opcode      = instr[OPC_LSB +: 8];
  assign alu_op      = instr[ALU_LSB +: 3];
  assign imm_sel     = instr[IMMSEL_BIT];
  assign rd_idx      = instr[RD_LSB +: REG_ADDR_WIDTH];
  assign rs0_idx     = instr[RS0_LSB +: REG_ADDR_WIDTH];
  assign rs1_idx     = instr[RS1_LSB +: REG_ADDR_WIDTH];
  assign imm         = instr[IMM_LSB +: DATA_WIDTH];
  assign alu_in0     = rf[rs0_idx];
  assign alu_in1     = imm_sel ? imm : rf[rs1_idx];
  assign pc_inc      = pc + PC_ONE;
  assign jump_target = imm[CMD_ADDR_WIDTH-1:0];
  assign pulse_ready = (qclk >= imm);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'd0: alu_result = alu_in0 + alu_in1;
      3'd1: alu_result = alu_in0 - alu_in1;
      3'd2: alu_result = alu_in0 & alu_in1;
      3'd3: alu_result = alu_in0 | alu_in1;
      3'd4: alu_result = alu_in0 ^ alu_in1;
      3'd5: alu_result = {{(DATA_WIDTH-1){1'b0}}, (alu_in0 == alu_in1)};
      3'd6: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(alu_in0) < $signed(alu_in1))};
      3'd7: alu_result = alu_in1;
      default: alu_result = '0;
    endcase
  end

  // Program memory survives reset; host writes land only while the core is parked.
  always_ff @(posedge clk) begin
    if (write_prog_enable && idle_like) begin
      prog_mem[cmd_addr] <= cmd_data;
    end
    if (state == S_FETCH) begin
      instr <= prog_mem[pc];
    end
  end

  // Handshake: sync_barrier_en_out / fproc_en_out rise the cycle after EXEC with their id
  // stable, stay high until the matching enable is sampled high in the wait state, and drop
  // on that same edge. Enables arriving in any other state are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_IDLE;
      pc                  <= '0;
      qclk                <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      cmd_out             <= '0;
      cstrobe             <= 1'b0;
      sync_barrier        <= '0;
      sync_barrier_en_out <= 1'b0;
      fproc_id            <= '0;
      fproc_en_out        <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      cstrobe <= 1'b0;
      if (!idle_like) begin
        qclk <= qclk + QCLK_ONE;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc    <= '0;
            qclk  <= '0;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (opcode)
            OP_ALU: begin
              rf[rd_idx] <= alu_result;
              pc         <= pc_inc;
              state      <= S_FETCH;
            end
            OP_JUMP: begin
              pc    <= jump_target;
              state <= S_FETCH;
            end
            OP_JUMP_COND: begin
              pc    <= alu_result[0] ? jump_target : pc_inc;
              state <= S_FETCH;
            end
            OP_PULSE: begin
              if (pulse_ready) begin
                cmd_out <= instr;
                cstrobe <= 1'b1;
                pc      <= pc_inc;
                state   <= S_FETCH;
              end else begin
                state <= S_WAIT_PULSE;
              end
            end
            OP_SYNC: begin
              sync_barrier        <= imm[SYNC_BARRIER_WIDTH-1:0];
              sync_barrier_en_out <= 1'b1;
              state               <= S_WAIT_SYNC;
            end
            OP_FPROC: begin
              fproc_id     <= imm[SYNC_BARRIER_WIDTH-1:0];
              fproc_en_out <= 1'b1;
              state        <= S_WAIT_FPROC;
            end
            OP_DONE: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end
            OP_QCLK_RST: begin
              qclk  <= '0;
              pc    <= pc_inc;
              state <= S_FETCH;
            end
            default: begin
              // OP_NOP and every undefined opcode simply advance.
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          endcase
        end
        S_WAIT_PULSE: begin
          if (pulse_ready) begin
            cmd_out <= instr;
            cstrobe <= 1'b1;
            pc      <= pc_inc;
            state   <= S_FETCH;
          end
        end
        S_WAIT_SYNC: begin
          if (sync_enable) begin
            sync_barrier_en_out <= 1'b0;
            pc                  <= pc_inc;
            state               <= S_FETCH;
          end
        end
        S_WAIT_FPROC: begin
          if (fproc_enable) begin
            fproc_en_out <= 1'b0;
            rf[rd_idx]   <= fproc_data;
            pc           <= pc_inc;
            state        <= S_FETCH;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core.sv
// Bench for proc_core: directed scenarios plus random straight-line programs, checked
// against an instruction-level reference interpreter with its own cycle accounting.
module tb_proc_core;

  localparam int DW   = 32;
  localparam int CW   = 128;
  localparam int AW   = 8;
  localparam int NREG = 16;

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_ALU       = 8'h01;
  localparam logic [7:0] OP_JUMP      = 8'h02;
  localparam logic [7:0] OP_JUMP_COND = 8'h03;
  localparam logic [7:0] OP_PULSE     = 8'h04;
  localparam logic [7:0] OP_SYNC      = 8'h05;
  localparam logic [7:0] OP_FPROC     = 8'h06;
  localparam logic [7:0] OP_DONE      = 8'h07;
  localparam logic [7:0] OP_QCLK_RST  = 8'h08;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          write_prog_enable;
  logic [AW-1:0] cmd_addr;
  logic [CW-1:0] cmd_data;
  logic          sync_enable;
  logic          fproc_enable;
  logic [DW-1:0] fproc_data;
  logic [CW-1:0] cmd_out;
  logic          cstrobe;
  logic [7:0]    sync_barrier;
  logic          sync_barrier_en_out;
  logic [7:0]    fproc_id;
  logic          fproc_en_out;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  proc_core dut (
    .clk                 (clk),
    .reset               (rst_n),
    .start               (start),
    .write_prog_enable   (write_prog_enable),
    .cmd_addr            (cmd_addr),
    .cmd_data            (cmd_data),
    .sync_enable         (sync_enable),
    .fproc_enable        (fproc_enable),
    .fproc_data          (fproc_data),
    .cmd_out             (cmd_out),
    .cstrobe             (cstrobe),
    .sync_barrier        (sync_barrier),
    .sync_barrier_en_out (sync_barrier_en_out),
    .fproc_id            (fproc_id),
    .fproc_en_out        (fproc_en_out),
    .busy                (busy),
    .done                (done),
    .state_dbg           (state_dbg)
  );

  // Cycle index since the start edge; equals qclk as long as no QCLK_RST ran.
  int run_cyc = 0;
  always @(posedge clk) begin
    if (start) run_cyc <= 0;
    else       run_cyc <= run_cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fails  = 0;
  logic [CW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  logic [CW-1:0] m_prog [256];
  logic [DW-1:0] m_regs [NREG];

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cstrobe) begin
      if (exp_q.size() == 0) begin
        check("cstrobe_unexpected", 1, 0);
      end else begin
        check("cmd_out", cmd_out, exp_q.pop_front());
        check("cstrobe_cycle", run_cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [CW-1:0] mk(input logic [7:0] op, input logic [2:0] aop,
                                       input logic isel, input logic [7:0] rd,
                                       input logic [7:0] rs0, input logic [7:0] rs1,
                                       input logic [31:0] imm, input logic [59:0] fill);
    logic [CW-1:0] w;
    w = '0;
    w[127:120] = op;
    w[119:117] = aop;
    w[116]     = isel;
    w[115:108] = rd;
    w[107:100] = rs0;
    w[99:92]   = rs1;
    w[91:60]   = imm;
    w[59:0]    = fill;
    return w;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [2:0] aop, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (aop)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a == b) ? 32'd1 : 32'd0;
      3'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return b;
    endcase
  endfunction

  // Each instruction costs fetch + exec; PULSE adds the cycles spent waiting for qclk >= imm.
  task automatic model_run(output int done_cyc, output logic [DW-1:0] fin_q);
    int            pc;
    int            c;
    int            d;
    logic [DW-1:0] q;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] r;
    logic [DW-1:0] imm;
    logic [CW-1:0] w;
    pc = 0; c = 0; q = 0; done_cyc = -1; fin_q = 0;
    for (int step = 0; step < 1000; step++) begin
      w   = m_prog[pc];
      imm = w[91:60];
      a   = m_regs[w[103:100]];
      b   = w[116] ? imm : m_regs[w[95:92]];
      r   = alu_ref(w[119:117], a, b);
      if (w[127:120] == OP_DONE) begin
        done_cyc = c + 2;
        fin_q    = q + 2;
        break;
      end
      case (w[127:120])
        OP_ALU:       begin m_regs[w[111:108]] = r; pc = (pc + 1) & 255; end
        OP_JUMP:      pc = int'(imm[7:0]);
        OP_JUMP_COND: pc = r[0] ? int'(imm[7:0]) : ((pc + 1) & 255);
        default:      pc = (pc + 1) & 255;
      endcase
      if (w[127:120] == OP_PULSE) begin
        d = ((q + 1) >= imm) ? 0 : int'(imm - (q + 1));
        exp_q.push_back(w);
        exp_cyc_q.push_back(c + 2 + d);
        c = c + 2 + d;
        q = q + 32'(2 + d);
      end else if (w[127:120] == OP_QCLK_RST) begin
        c = c + 2;
        q = 0;
      end else begin
        c = c + 2;
        q = q + 2;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load(input int addr, input logic [CW-1:0] w);
    m_prog[addr] = w;
    @(negedge clk);
    write_prog_enable = 1'b1;
    cmd_addr          = addr[AW-1:0];
    cmd_data          = w;
    @(negedge clk);
    write_prog_enable = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int n = 0; n < 3000; n++) begin
      if (done) begin
        cyc = run_cyc;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) check("done_timeout", 0, 1);
  endtask

  task automatic wait_req(input bit is_sync, output int cyc);
    cyc = -1;
    for (int n = 0; n < 50; n++) begin
      if (is_sync ? sync_barrier_en_out : fproc_en_out) begin
        cyc = run_cyc;
        break;
      end
      @(negedge clk);
    end
    if (cyc < 0) check("request_timeout", 0, 1);
  endtask

  task automatic check_regs();
    for (int i = 0; i < NREG; i++) check("reg", dut.rf[i], m_regs[i]);
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_out", cmd_out, 0);
    check("rst_cstrobe", cstrobe, 0);
    check("rst_sync_barrier", sync_barrier, 0);
    check("rst_sync_en", sync_barrier_en_out, 0);
    check("rst_fproc_id", fproc_id, 0);
    check("rst_fproc_en", fproc_en_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    check("rst_qclk", dut.qclk, 0);
  endtask

  task automatic run_checked(output int got_done);
    int            exp_done;
    logic [DW-1:0] exp_fin_q;
    model_run(exp_done, exp_fin_q);
    pulse_start();
    wait_done(got_done);
    check("done_cycle", got_done, exp_done);
    check("busy_after_done", busy, 0);
    check("qclk_final", dut.qclk, exp_fin_q);
    check("strobes_left", exp_q.size(), 0);
    check_regs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int            dc;
    int            rc;
    int            len;
    int            sel;
    int            tgt;
    logic [CW-1:0] w;

    rst_n = 1'b0; start = 1'b0; write_prog_enable = 1'b0; cmd_addr = '0; cmd_data = '0;
    sync_enable = 1'b0; fproc_enable = 1'b0; fproc_data = '0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    check_regs();
    rst_n = 1'b1;

    // R1 <- 5, R2 <- R1 + R1, DONE
    load(0, mk(OP_ALU, 3'd7, 1'b1, 8'd1, 8'd0, 8'd0, 32'd5, 60'd0));
    load(1, mk(OP_ALU, 3'd0, 1'b0, 8'd2, 8'd1, 8'd1, 32'd0, 60'd0));
    load(2, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    run_checked(dc);
    check("plan_r2", dut.rf[2], 10);
    check("plan_done_cycle", dc, 6);

    // Counting loop reached through a truncated jump target, leaving via pc wrap at 255.
    load(0,   mk(OP_JUMP_COND, 3'd7, 1'b0, 8'd0, 8'd0, 8'd6, 32'd10, 60'd0));
    load(1,   mk(OP_JUMP, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'h1FA, 60'd0));
    load(250, mk(OP_ALU, 3'd7, 1'b1, 8'd6, 8'd0, 8'd0, 32'd1, 60'd0));
    load(251, mk(OP_ALU, 3'd7, 1'b1, 8'd1, 8'd0, 8'd0, 32'd0, 60'd0));
    load(252, mk(OP_ALU, 3'd7, 1'b1, 8'd3, 8'd0, 8'd0, 32'd3, 60'd0));
    load(253, mk(OP_ALU, 3'd0, 1'b1, 8'd1, 8'd1, 8'd0, 32'd1, 60'd0));
    load(254, mk(OP_JUMP_COND, 3'd6, 1'b0, 8'd0, 8'd1, 8'd3, 32'd253, 60'd0));
    load(255, mk(OP_NOP, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    load(10,  mk(OP_ALU, 3'd7, 1'b1, 8'd6, 8'd0, 8'd0, 32'd0, 60'd0));
    load(11,  mk(OP_JUMP, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'h10C, 60'd0));
    load(12,  mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    run_checked(dc);
    check("loop_r1", dut.rf[1], 3);

    // PULSE that must wait for qclk, then one that fires straight from EXEC.
    load(0, mk(OP_PULSE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd20, 60'hABC_DEF0_1234));
    load(1, mk(OP_PULSE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'h555));
    load(2, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    run_checked(dc);

    // SYNC barrier held for 10 cycles before release.
    load(0, mk(OP_SYNC, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'h3C, 60'd0));
    load(1, mk(OP_ALU, 3'd7, 1'b1, 8'd5, 8'd0, 8'd0, 32'h55, 60'd0));
    load(2, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    pulse_start();
    wait_req(1'b1, rc);
    check("sync_req_cycle", rc, 2);
    for (int i = 0; i < 10; i++) begin
      check("sync_en_held", sync_barrier_en_out, 1);
      check("sync_id_held", sync_barrier, 8'h3C);
      @(negedge clk);
    end
    sync_enable = 1'b1;
    rc = run_cyc;
    @(negedge clk);
    sync_enable = 1'b0;
    check("sync_en_drop", sync_barrier_en_out, 0);
    wait_done(dc);
    check("sync_done_cycle", dc, rc + 5);
    m_regs[5] = 32'h55;
    check("sync_next_instr", dut.rf[5], 32'h55);

    // FPROC: enables before the wait state are ignored, then the result lands in R4.
    load(0, mk(OP_NOP, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    load(1, mk(OP_FPROC, 3'd0, 1'b0, 8'd4, 8'd0, 8'd0, 32'd7, 60'd0));
    load(2, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    pulse_start();
    fproc_enable = 1'b1;
    fproc_data   = 32'hBAD0BAD0;
    repeat (4) @(negedge clk);
    fproc_enable = 1'b0;
    wait_req(1'b0, rc);
    check("fproc_req_cycle", rc, 4);
    check("fproc_early_ignored", dut.rf[4], m_regs[4]);
    for (int i = 0; i < 3; i++) begin
      check("fproc_en_held", fproc_en_out, 1);
      check("fproc_id_held", fproc_id, 8'd7);
      @(negedge clk);
    end
    fproc_enable = 1'b1;
    fproc_data   = 32'hDEADBEEF;
    rc = run_cyc;
    @(negedge clk);
    fproc_enable = 1'b0;
    check("fproc_en_drop", fproc_en_out, 0);
    wait_done(dc);
    check("fproc_done_cycle", dc, rc + 3);
    m_regs[4] = 32'hDEADBEEF;
    check("fproc_writeback", dut.rf[4], 32'hDEADBEEF);

    // Random straight-line programs with forward conditional skips.
    for (int p = 0; p < 10; p++) begin
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(0, 9);
        w = mk(OP_ALU, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               8'($urandom), 8'($urandom), 8'($urandom), $urandom,
               {28'($urandom), $urandom});
        tgt = (i + 2 > len) ? len : i + 2;
        case (sel)
          5: w[127:120] = OP_PULSE;
          6: w[127:120] = OP_NOP;
          7: w[127:120] = 8'($urandom_range(9, 255));
          8: w[127:120] = OP_QCLK_RST;
          9: w[127:120] = OP_JUMP_COND;
          default: ;
        endcase
        if (sel == 5) w[91:60] = 32'($urandom_range(0, 30));
        if (sel == 9) w[91:60] = 32'(tgt);
        load(i, w);
      end
      load(len, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
      run_checked(dc);
    end

    // Reset in the middle of a sync wait; a write attempted while busy must be dropped.
    load(0, mk(OP_SYNC, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'h11, 60'd0));
    load(1, mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0));
    pulse_start();
    wait_req(1'b1, rc);
    write_prog_enable = 1'b1;
    cmd_addr          = 8'd0;
    cmd_data          = mk(OP_DONE, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 32'd0, 60'd0);
    @(negedge clk);
    write_prog_enable = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_req(1'b1, rc);
    check("mem_intact_sync_id", sync_barrier, 8'h11);
    sync_enable = 1'b1;
    @(negedge clk);
    sync_enable = 1'b0;
    wait_done(dc);
    check("after_reset_done", done, 1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
